// File: rtl/sobel_stream_sink_if.sv
// Bundles the pixel input stream and the frame-buffer write port of sobel_stream_sink.
// The slave side is the sink itself; the master side drives pixels and write accepts.
interface sobel_stream_sink_if;
  logic        iDVAL;
  logic [11:0] iDATA;
  logic        oWR_REQ;
  logic [18:0] oWR_ADDR;
  logic [11:0] oWR_DATA;
  logic        iWR_ACK;
  logic        oFRAME_DONE;
  logic        oOVERFLOW;
  logic        oBUSY;

  modport slave (
    input  iDVAL,
    input  iDATA,
    input  iWR_ACK,
    output oWR_REQ,
    output oWR_ADDR,
    output oWR_DATA,
    output oFRAME_DONE,
    output oOVERFLOW,
    output oBUSY
  );

  modport master (
    output iDVAL,
    output iDATA,
    output iWR_ACK,
    input  oWR_REQ,
    input  oWR_ADDR,
    input  oWR_DATA,
    input  oFRAME_DONE,
    input  oOVERFLOW,
    input  oBUSY
  );
endinterface

// File: rtl/sobel_stream_sink.sv
// Sobel result sink: converts signed gradients to magnitudes (optionally binarized),
// tags each pixel with its linear frame address, queues it in a small FIFO and writes
// it to a frame buffer over a req/ack port. Tracks frame completion through a drain phase.
module sobel_stream_sink #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned THRESH     = 0
) (
  input logic                iCLK,
  input logic                iRST,
  sobel_stream_sink_if.slave bus
);

  localparam int unsigned NumPix   = WIDTH * HEIGHT;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam logic [18:0] LastAddr = 19'(NumPix - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e          state_q, state_d;
  logic [18:0]     pix_cnt_q, pix_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic            overflow_q, overflow_d;

  logic [18:0] addr_mem [FIFO_DEPTH];
  logic [11:0] data_mem [FIFO_DEPTH];

  logic [11:0] mag;
  logic [11:0] value;
  logic        empty, full, push, pop, last_pix, frame_done;

  // Gradient magnitude with -2048 clamped, then optional binarization
  always_comb begin
    mag   = bus.iDATA;
    value = '0;
    if (bus.iDATA == 12'h800) begin
      mag = 12'd2047;
    end else if (bus.iDATA[11]) begin
      mag = -bus.iDATA;
    end
    if (THRESH == 0) begin
      value = mag;
    end else begin
      value = (32'(mag) >= THRESH) ? 12'hFFF : 12'h000;
    end
  end

  // FIFO control: a full FIFO still accepts when the head leaves in the same cycle
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CntW'(FIFO_DEPTH));
    pop        = !empty && bus.iWR_ACK;
    push       = bus.iDVAL && (!full || pop);
    overflow_d = overflow_q || (bus.iDVAL && !push);
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
  end

  // Pixel address counter advances on every valid pixel, dropped or not
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    last_pix  = bus.iDVAL && (pix_cnt_q == LastAddr);
    if (bus.iDVAL) begin
      pix_cnt_d = last_pix ? '0 : pix_cnt_q + 19'd1;
    end
  end

  // Frame FSM; the drain counter only tracks entries queued before the frame ended,
  // so pixels of the next frame arriving during drain queue behind them uncounted.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle, StStream: begin
        if (last_pix) begin
          state_d = StDrain;
          drain_d = count_d;
        end else if (bus.iDVAL) begin
          state_d = StStream;
        end
      end
      StDrain: begin
        if (drain_q == '0) begin
          frame_done = 1'b1;
          state_d    = (pix_cnt_d != '0) ? StStream : StIdle;
        end else if (pop) begin
          drain_d = drain_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state registers
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= StIdle;
      pix_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drain_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pix_cnt_q  <= pix_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; left unreset because the head outputs are masked while empty
  always_ff @(posedge iCLK) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= pix_cnt_q;
      data_mem[wr_ptr_q] <= value;
    end
  end

  assign bus.oWR_REQ     = !empty;
  assign bus.oWR_ADDR    = empty ? '0 : addr_mem[rd_ptr_q];
  assign bus.oWR_DATA    = empty ? '0 : data_mem[rd_ptr_q];
  assign bus.oFRAME_DONE = frame_done;
  assign bus.oOVERFLOW   = overflow_q;
  assign bus.oBUSY       = (state_q != StIdle);

endmodule

// File: doc/sobel_stream_sink.md
SOBEL_STREAM_SINK -- requirements
Module: sobel_stream_sink

Interface
REQ-001 Parameters SHALL be: WIDTH, 640, pixels per row; HEIGHT, 480, rows per frame; FIFO_DEPTH, 16, entries (power of 2); THRESH, 0, binarize level (0 = pass magnitude).
REQ-002 Ports SHALL be: iCLK  in  1  clock, all logic on rising edge.
REQ-003 iRST  in  1  asynchronous active-low reset.
REQ-004 iDVAL  in  1  input pixel valid, one pixel per asserted cycle.
REQ-005 iDATA  in  12  signed two's-complement Sobel result.
REQ-006 oWR_REQ  out  1  write request to frame buffer.
REQ-007 oWR_ADDR  out  19  linear pixel address (Y*WIDTH+X).
REQ-008 oWR_DATA  out  12  unsigned pixel value.
REQ-009 iWR_ACK  in  1  frame-buffer accept, valid only while oWR_REQ high.
REQ-010 oFRAME_DONE  out  1  one-cycle pulse, frame fully written.
REQ-011 oOVERFLOW  out  1  sticky, pixel dropped.
REQ-012 oBUSY  out  1  high when state is not IDLE.

Function
REQ-013 Magnitude SHALL be |iDATA|; -2048 saturates to 2047.
REQ-014 THRESH=0: value = magnitude; THRESH>0: value = 12'hFFF if magnitude >= THRESH, else 0.
REQ-015 Pixel counter SHALL increment on every iDVAL cycle, wrapping from WIDTH*HEIGHT-1 to 0.
REQ-016 Each iDVAL cycle SHALL push {counter, value} into the FIFO when it is not full or a pop occurs in the same cycle.
REQ-017 iDVAL with FIFO full and no same-cycle pop SHALL drop the pixel and set oOVERFLOW; the counter still advances.
REQ-018 oWR_REQ SHALL equal FIFO non-empty; oWR_ADDR/oWR_DATA SHALL present the FIFO head.
REQ-019 Transfer SHALL occur on oWR_REQ && iWR_ACK; the head then pops.
REQ-020 Head outputs SHALL stay stable while oWR_REQ is high and iWR_ACK is low.
REQ-021 A pixel pushed into an empty FIFO at edge N SHALL appear with oWR_REQ high after edge N (1-cycle latency).
REQ-022 Throughput SHALL be one pixel per cycle with iWR_ACK held high.
REQ-023 FSM states SHALL be IDLE, STREAM and DRAIN.
REQ-024 IDLE -> STREAM on iDVAL.
REQ-025 STREAM -> DRAIN on the iDVAL cycle carrying address WIDTH*HEIGHT-1.
REQ-026 On entering DRAIN, drain counter SHALL load the post-push FIFO occupancy of old-frame entries; it decrements per pop.
REQ-027 DRAIN SHALL end when the drain counter reaches 0, pulsing oFRAME_DONE for exactly one cycle.
REQ-028 On leaving DRAIN, the next state SHALL be STREAM if the pixel counter is nonzero, else IDLE.
REQ-029 iDVAL during DRAIN SHALL be accepted as the next frame (address 0 upward), queued behind old-frame entries, and not counted by the drain counter.
REQ-030 A dropped last pixel SHALL still trigger STREAM -> DRAIN.
REQ-031 If DRAIN is entered with 0 old entries, oFRAME_DONE SHALL pulse on the next cycle.
REQ-032 iWR_ACK while oWR_REQ is low SHALL be ignored.

Reset
REQ-033 While iRST is low: oWR_REQ=0, oWR_ADDR=0, oWR_DATA=0, oFRAME_DONE=0, oOVERFLOW=0, oBUSY=0, FIFO empty, counter=0, state IDLE.
REQ-034 Reset mid-frame SHALL discard FIFO contents; the next iDVAL after release is address 0.
REQ-035 oOVERFLOW SHALL clear only by reset.

Verification
REQ-036 Single pixel: iDVAL with iDATA=-5 -> next cycle oWR_REQ=1, oWR_ADDR=0, oWR_DATA=5; ack -> oWR_REQ=0.
REQ-037 Saturation/threshold: iDATA=12'h800 -> 2047; with THRESH=100, iDATA=99 -> 0 and iDATA=-100 -> 12'hFFF.
REQ-038 Backpressure: 17 consecutive iDVAL with iWR_ACK=0 (depth 16) -> 16 entries queued, 17th dropped, oOVERFLOW=1; address 16 still consumed, next pixel gets address 17.
REQ-039 Full frame (WIDTH=4, HEIGHT=2, ack always high) -> addresses 0..7 in order, oFRAME_DONE pulses once after address 7 transfers, then IDLE, oBUSY=0.
REQ-040 Frame overlap: next frame pixels start during DRAIN with ack stalled 3 cycles -> oFRAME_DONE pulses after old address 7 pops, before new address 0, state STREAM.
REQ-041 Reset asserted with 5 entries queued -> all outputs 0 immediately; after release, first pixel gets address 0.
